alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU (operands A/B, 6-bit ALUFun, Sign; results Z/V) between two requesters.
  - Port 0: main pipeline side.
  - Port 1: auxiliary unit, e.g. peripheral/interrupt address arithmetic.
- Round-robin arbitration with valid/ready handshakes on both request and response.
- Registered ALU operands and a registered result; exactly one operation in flight.
- Sits between the requesters and the ALU instance in the CPU top level.

Parameters:
- WIDTH, 32, operand and result width.
- FUN_W, 6, ALUFun width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_A  input  WIDTH  port 0 operand A
- req0_B  input  WIDTH  port 0 operand B
- req0_ALUFun  input  FUN_W  port 0 function code
- req0_Sign  input  1  port 0 signed-arithmetic flag
- rsp0_valid  output  1  port 0 result valid
- rsp0_ready  input  1  port 0 consumes result
- rsp0_Z  output  WIDTH  port 0 result
- rsp0_V  output  1  port 0 overflow flag
- req1_valid, req1_ready, req1_A, req1_B, req1_ALUFun, req1_Sign, rsp1_valid, rsp1_ready, rsp1_Z, rsp1_V: same directions, widths and meanings as the port 0 signals, for port 1.
- alu_A  output  WIDTH  registered operand A to ALU
- alu_B  output  WIDTH  registered operand B to ALU
- alu_ALUFun  output  FUN_W  registered function to ALU
- alu_Sign  output  1  registered Sign to ALU
- alu_Z  input  WIDTH  ALU result (combinational from alu_* outputs)
- alu_V  input  1  ALU overflow

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset is synchronous, active-high.
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - State IDLE; priority pointer = 0 (port 0 favoured).
  - All alu_* outputs = 0.
  - rspN_valid = 0, rspN_Z = 0, rspN_V = 0, reqN_ready = 0.
  - Owner register = 0.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE.
  - Both valid: grant the port indicated by the pointer.
  - One valid: grant that port.
  - Exactly one reqN_ready high per cycle, and only for the granted port.
  - reqN_ready does not depend on the port's own reqN_valid value other than through grant selection.
- On handshake (valid & ready):
  - Latch the port's A, B, ALUFun and Sign into the alu_* registers.
  - Record the owner.
  - Set pointer = other port.
  - Go to EXEC.
- EXEC (one cycle):
  - Sample alu_Z and alu_V into the owner's rsp registers.
  - Set rsp{owner}_valid = 1.
  - Go to RESP.
- RESP:
  - Hold rsp{owner}_valid, rsp_Z and rsp_V stable until rsp{owner}_ready.
  - On rsp{owner}_ready: clear valid and go to IDLE.
  - The next grant can occur in that same IDLE cycle.
- Timing:
  - Latency: request accepted at cycle t → rsp valid from cycle t+2.
  - Minimum issue interval with rsp_ready tied high: 3 cycles.
- The non-owner's rsp_valid stays 0. alu_* outputs hold their last values outside EXEC.
- Z/V are passed through unchanged. The arbiter performs no arithmetic and does not decode ALUFun.
- Requests arriving during EXEC or RESP are not accepted; a requester holds valid and its operands stable until ready.
- Reset mid-operation:
  - Any state returns to IDLE and the in-flight operation is dropped.
  - No response is issued afterwards.
- Round-robin fairness: under continuous requests on both ports, grants strictly alternate.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid, and the pointer register is removed.
- Undefined: round-robin as above (default build).

Test Plan:
- Port 0 add:
  - Stimulus: after reset, req0 A=3, B=5, ALUFun=000000, Sign=1; rsp0_ready=1.
  - Response: req0_ready high in the accept cycle; rsp0_valid exactly 2 cycles later with rsp0_Z=8, rsp0_V=0; rsp1_valid stays 0.
- Port 1 shift:
  - Stimulus: req1 A=0x1D, B=0x00000001, ALUFun=100000 (SLL).
  - Response: rsp1_Z=0x20000000; ALUFun=100001 (SRL) with B=0x80000001 → 0x00000004.
- Signed overflow:
  - Stimulus: req0 A=0x7FFFFFFF, B=0x00000001, ALUFun=000000, Sign=1.
  - Response: rsp0_Z=0x80000000, rsp0_V=1.
- Contention:
  - Stimulus: both valid continuously from reset, rsp ready high.
  - Response: grants 0,1,0,1 with 3-cycle spacing.
  - With ALU_ARB_FIXED_PRIO_EN: grants 0,0,0.
- Backpressure:
  - Stimulus: rsp0_ready=0 for 5 cycles after rsp0_valid, then 1; req1 valid throughout.
  - Response: rsp0_Z/V remain stable; req1_ready stays 0 until the cycle after the rsp0 handshake, then port 1 is granted.
- Reset mid-op:
  - Stimulus: assert reset in EXEC.
  - Response: next cycle state IDLE, all rsp_valid=0, alu_* = 0, no stale response afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters (port 0 =
//            main pipeline, port 1 = auxiliary unit). Requests and responses
//            use valid/ready handshakes; exactly one operation is in flight.
//            Grants are round-robin by default. Building with the macro
//            ALU_ARB_FIXED_PRIO_EN gives port 0 fixed priority and removes
//            the priority pointer.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            reqN_*            - request handshake + operands (N = 0, 1)
//            rspN_*            - response handshake + result Z / overflow V
//            alu_A/B/ALUFun/Sign (out) - registered operands to the ALU
//            alu_Z/V (in)      - combinational ALU result
// Timing   : request accepted in cycle t -> rspN_valid from cycle t+2.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int FUN_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   // port 0 request / response
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_A,
   input  logic [WIDTH-1:0] req0_B,
   input  logic [FUN_W-1:0] req0_ALUFun,
   input  logic             req0_Sign,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_Z,
   output logic             rsp0_V,
   // port 1 request / response
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_A,
   input  logic [WIDTH-1:0] req1_B,
   input  logic [FUN_W-1:0] req1_ALUFun,
   input  logic             req1_Sign,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_Z,
   output logic             rsp1_V,
   // shared ALU
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [FUN_W-1:0] alu_ALUFun,
   output logic             alu_Sign,
   input  logic [WIDTH-1:0] alu_Z,
   input  logic             alu_V
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e             state_q,      state_d;
   logic               owner_q,      owner_d;
   logic [WIDTH-1:0]   alu_A_q,      alu_A_d;
   logic [WIDTH-1:0]   alu_B_q,      alu_B_d;
   logic [FUN_W-1:0]   alu_ALUFun_q, alu_ALUFun_d;
   logic               alu_Sign_q,   alu_Sign_d;
   logic               rsp0_valid_q, rsp0_valid_d;
   logic [WIDTH-1:0]   rsp0_Z_q,     rsp0_Z_d;
   logic               rsp0_V_q,     rsp0_V_d;
   logic               rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0]   rsp1_Z_q,     rsp1_Z_d;
   logic               rsp1_V_q,     rsp1_V_d;

   logic grant;        // port offered the request slot while idle
   logic accept;       // request handshake on the granted port
   logic owner_ready;  // response consumer of the current owner

   // ------------------------------------------------------------------------
   // Grant selection. With no request pending the offer still goes to one
   // port, so exactly one reqN_ready is high in every idle cycle and ready
   // never depends on the port's own valid except through this selection.
   // ------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant = req1_valid & ~req0_valid;
   end
`else
   logic ptr_q, ptr_d;

   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ptr_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end else if (req0_valid) begin
         grant = 1'b0;
      end else begin
         grant = ptr_q;
      end
   end

   // Favour the other port after every accepted request.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = ~grant;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      alu_A_d      = alu_A_q;
      alu_B_d      = alu_B_q;
      alu_ALUFun_d = alu_ALUFun_q;
      alu_Sign_d   = alu_Sign_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp0_Z_d     = rsp0_Z_q;
      rsp0_V_d     = rsp0_V_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp1_Z_d     = rsp1_Z_q;
      rsp1_V_d     = rsp1_V_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      accept       = 1'b0;
      owner_ready  = owner_q ? rsp1_ready : rsp0_ready;

      case (state_q)
         IDLE: begin
            // Ready is suppressed while reset is asserted so that nothing
            // appears accepted during the reset cycle.
            if (!reset) begin
               req0_ready = ~grant;
               req1_ready = grant;
               accept     = grant ? req1_valid : req0_valid;
            end
            if (accept) begin
               owner_d      = grant;
               alu_A_d      = grant ? req1_A      : req0_A;
               alu_B_d      = grant ? req1_B      : req0_B;
               alu_ALUFun_d = grant ? req1_ALUFun : req0_ALUFun;
               alu_Sign_d   = grant ? req1_Sign   : req0_Sign;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            // The ALU has had a full cycle on the registered operands.
            if (owner_q) begin
               rsp1_Z_d     = alu_Z;
               rsp1_V_d     = alu_V;
               rsp1_valid_d = 1'b1;
            end else begin
               rsp0_Z_d     = alu_Z;
               rsp0_V_d     = alu_V;
               rsp0_valid_d = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (owner_ready) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         alu_A_q      <= '0;
         alu_B_q      <= '0;
         alu_ALUFun_q <= '0;
         alu_Sign_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp0_Z_q     <= '0;
         rsp0_V_q     <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_Z_q     <= '0;
         rsp1_V_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         alu_A_q      <= alu_A_d;
         alu_B_q      <= alu_B_d;
         alu_ALUFun_q <= alu_ALUFun_d;
         alu_Sign_q   <= alu_Sign_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_Z_q     <= rsp0_Z_d;
         rsp0_V_q     <= rsp0_V_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_Z_q     <= rsp1_Z_d;
         rsp1_V_q     <= rsp1_V_d;
      end
   end

   assign alu_A      = alu_A_q;
   assign alu_B      = alu_B_q;
   assign alu_ALUFun = alu_ALUFun_q;
   assign alu_Sign   = alu_Sign_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_Z     = rsp0_Z_q;
   assign rsp0_V     = rsp0_V_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_Z     = rsp1_Z_q;
   assign rsp1_V     = rsp1_V_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. A behavioural ALU drives
//            alu_Z/alu_V; expected results and grant order come from a
//            reference function and a one-variable fairness model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

   localparam int W  = 32;
   localparam int FW = 6;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req0_Sign;
   logic [W-1:0]  req0_A, req0_B;
   logic [FW-1:0] req0_ALUFun;
   logic          rsp0_valid, rsp0_ready, rsp0_V;
   logic [W-1:0]  rsp0_Z;
   logic          req1_valid, req1_ready, req1_Sign;
   logic [W-1:0]  req1_A, req1_B;
   logic [FW-1:0] req1_ALUFun;
   logic          rsp1_valid, rsp1_ready, rsp1_V;
   logic [W-1:0]  rsp1_Z;
   logic [W-1:0]  alu_A, alu_B, alu_Z;
   logic [FW-1:0] alu_ALUFun;
   logic          alu_Sign, alu_V;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W), .FUN_W(FW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
      .req0_B(req0_B), .req0_ALUFun(req0_ALUFun), .req0_Sign(req0_Sign),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_Z(rsp0_Z),
      .rsp0_V(rsp0_V),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
      .req1_B(req1_B), .req1_ALUFun(req1_ALUFun), .req1_Sign(req1_Sign),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_Z(rsp1_Z),
      .rsp1_V(rsp1_V),
      .alu_A(alu_A), .alu_B(alu_B), .alu_ALUFun(alu_ALUFun),
      .alu_Sign(alu_Sign), .alu_Z(alu_Z), .alu_V(alu_V)
   );

   // Behavioural ALU: returns {V, Z}. Shifts move B by A[4:0].
   function automatic logic [W:0] alu_ref(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [FW-1:0] f,
                                          input logic s);
      logic [W-1:0] z;
      logic         v;
      z = '0;
      v = 1'b0;
      case (f)
         6'b000000: begin
            z = a + b;
            v = s & (a[W-1] == b[W-1]) & (z[W-1] != a[W-1]);
         end
         6'b000001: begin
            z = a - b;
            v = s & (a[W-1] != b[W-1]) & (z[W-1] != a[W-1]);
         end
         6'b011000: z = a & b;
         6'b011110: z = a | b;
         6'b010110: z = a ^ b;
         6'b010001: z = ~(a | b);
         6'b011010: z = a;
         6'b100000: z = b << a[4:0];
         6'b100001: z = b >> a[4:0];
         6'b100011: z = $signed(b) >>> a[4:0];
         default:   z = '0;
      endcase
      return {v, z};
   endfunction

   assign {alu_V, alu_Z} = alu_ref(alu_A, alu_B, alu_ALUFun, alu_Sign);

   function automatic logic [FW-1:0] pick_op();
      case ($urandom_range(0, 9))
         0: return 6'b000000;
         1: return 6'b000001;
         2: return 6'b011000;
         3: return 6'b011110;
         4: return 6'b010110;
         5: return 6'b010001;
         6: return 6'b011010;
         7: return 6'b100000;
         8: return 6'b100001;
         default: return 6'b100011;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_ALUFun = '0; req0_Sign = 1'b0;
      req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_ALUFun = '0; req1_Sign = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Presents one request and waits (bounded) for its ready. Returns the
   // number of cycles waited, or -1 on timeout. Leaves time in cycle t+1.
   task automatic do_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [FW-1:0] f, input logic s, output int waited);
      waited = -1;
      if (p == 0) begin
         req0_A = a; req0_B = b; req0_ALUFun = f; req0_Sign = s; req0_valid = 1'b1;
      end else begin
         req1_A = a; req1_B = b; req1_ALUFun = f; req1_Sign = s; req1_valid = 1'b1;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
            waited = i;
            break;
         end
         tick();
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   // Waits (bounded) for rspN_valid; returns cycles waited (-1 on timeout)
   // and the sampled result. Leaves time at the negedge of the valid cycle.
   task automatic wait_rsp(input int p, output int lat, output logic [W-1:0] z,
                           output logic v);
      lat = -1;
      z   = '0;
      v   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (p == 0 && rsp0_valid) begin
            lat = i; z = rsp0_Z; v = rsp0_V;
            break;
         end
         if (p == 1 && rsp1_valid) begin
            lat = i; z = rsp1_Z; v = rsp1_V;
            break;
         end
         tick();
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
      end
      checks++;
      if ({alu_A, alu_B, alu_ALUFun, alu_Sign} !== '0) begin
         errors++; $display("FAIL reset_alu got A=%h B=%h F=%b S=%b exp all 0",
                             alu_A, alu_B, alu_ALUFun, alu_Sign);
      end
      checks++;
      if ({rsp0_valid, rsp0_Z, rsp0_V, rsp1_valid, rsp1_Z, rsp1_V} !== '0) begin
         errors++; $display("FAIL reset_rsp got v0=%b z0=%h V0=%b v1=%b z1=%h V1=%b exp all 0",
                             rsp0_valid, rsp0_Z, rsp0_V, rsp1_valid, rsp1_Z, rsp1_V);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL reset_idle_offer got=%b exp=10", {req0_ready, req1_ready});
      end
      tick();
   endtask

   task automatic test_port0_add();
      int w, lat;
      logic [W-1:0] z;
      logic v;
      clear_inputs();
      do_reset();
      do_req(0, 32'd3, 32'd5, 6'b000000, 1'b1, w);
      checks++;
      if (w !== 0) begin
         errors++; $display("FAIL add_accept_wait got=%0d exp=0", w);
      end
      wait_rsp(0, lat, z, v);
      checks++;
      if (lat !== 1) begin
         errors++; $display("FAIL add_latency got=%0d exp=1", lat);
      end
      checks++;
      if ({v, z} !== {1'b0, 32'd8}) begin
         errors++; $display("FAIL add_result got Z=%h V=%b exp Z=00000008 V=0", z, v);
      end
      checks++;
      if (rsp1_valid !== 1'b0) begin
         errors++; $display("FAIL add_rsp1_quiet got=%b exp=0", rsp1_valid);
      end
      tick();
   endtask

   task automatic test_port1_shift();
      int w, lat;
      logic [W-1:0] z;
      logic v;
      clear_inputs();
      do_reset();
      do_req(1, 32'h1D, 32'h1, 6'b100000, 1'b0, w);
      checks++;
      if (w !== 0) begin
         errors++; $display("FAIL sll_accept_wait got=%0d exp=0", w);
      end
      wait_rsp(1, lat, z, v);
      checks++;
      if (lat !== 1 || z !== 32'h2000_0000) begin
         errors++; $display("FAIL sll_result got lat=%0d Z=%h exp lat=1 Z=20000000", lat, z);
      end
      checks++;
      if (rsp0_valid !== 1'b0) begin
         errors++; $display("FAIL sll_rsp0_quiet got=%b exp=0", rsp0_valid);
      end
      tick();
      do_req(1, 32'h1D, 32'h8000_0001, 6'b100001, 1'b0, w);
      checks++;
      if (w !== 0) begin
         errors++; $display("FAIL srl_accept_wait got=%0d exp=0", w);
      end
      wait_rsp(1, lat, z, v);
      checks++;
      if (lat !== 1 || z !== 32'h0000_0004) begin
         errors++; $display("FAIL srl_result got lat=%0d Z=%h exp lat=1 Z=00000004", lat, z);
      end
      tick();
   endtask

   task automatic test_overflow();
      int w, lat;
      logic [W-1:0] z;
      logic v;
      clear_inputs();
      do_reset();
      do_req(0, 32'h7FFF_FFFF, 32'h1, 6'b000000, 1'b1, w);
      wait_rsp(0, lat, z, v);
      checks++;
      if (w !== 0 || lat !== 1 || z !== 32'h8000_0000 || v !== 1'b1) begin
         errors++; $display("FAIL ovf_result got wait=%0d lat=%0d Z=%h V=%b exp 0 1 80000000 1",
                             w, lat, z, v);
      end
      tick();
   endtask

   task automatic test_contention();
      int gport[$];
      int gcyc[$];
      int both_hi;
      int exp_port;
      clear_inputs();
      req0_A = $urandom; req0_B = $urandom; req0_ALUFun = 6'b000000; req0_Sign = 1'b1;
      req1_A = $urandom; req1_B = $urandom; req1_ALUFun = 6'b010110; req1_Sign = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      do_reset();
      both_hi = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) both_hi++;
         if (req0_valid && req0_ready) begin gport.push_back(0); gcyc.push_back(c); end
         if (req1_valid && req1_ready) begin gport.push_back(1); gcyc.push_back(c); end
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (both_hi !== 0) begin
         errors++; $display("FAIL cont_one_ready got=%0d double-ready cycles exp=0", both_hi);
      end
      checks++;
      if (gport.size() !== 4) begin
         errors++; $display("FAIL cont_grant_count got=%0d exp=4", gport.size());
      end
      for (int k = 0; k < gport.size() && k < 4; k++) begin
         exp_port = FIXED_PRIO ? 0 : (k % 2);
         checks++;
         if (gport[k] !== exp_port || gcyc[k] !== 3 * k) begin
            errors++; $display("FAIL cont_grant%0d got port=%0d cycle=%0d exp port=%0d cycle=%0d",
                                k, gport[k], gcyc[k], exp_port, 3 * k);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a0, b0, a1, b1, z;
      logic [W:0]   e0, e1;
      logic v;
      int lat;
      clear_inputs();
      do_reset();
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      e0 = alu_ref(a0, b0, 6'b000000, 1'b1);
      e1 = alu_ref(a1, b1, 6'b000001, 1'b1);
      rsp0_ready = 1'b0;
      req0_A = a0; req0_B = b0; req0_ALUFun = 6'b000000; req0_Sign = 1'b1; req0_valid = 1'b1;
      req1_A = a1; req1_B = b1; req1_ALUFun = 6'b000001; req1_Sign = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL bp_first_grant got=%b exp=10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b0) begin
         errors++; $display("FAIL bp_exec_ready1 got=%b exp=0", req1_ready);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         checks++;
         if (rsp0_valid !== 1'b1 || rsp0_Z !== e0[W-1:0] || rsp0_V !== e0[W] || req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d got v=%b Z=%h V=%b rdy1=%b exp v=1 Z=%h V=%b rdy1=0",
                                i, rsp0_valid, rsp0_Z, rsp0_V, req1_ready, e0[W-1:0], e0[W]);
         end
      end
      tick();
      rsp0_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL bp_handshake got v0=%b rdy1=%b exp v0=1 rdy1=0", rsp0_valid, req1_ready);
      end
      tick();
      rsp0_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
         errors++; $display("FAIL bp_port1_grant got v0=%b rdy1=%b exp v0=0 rdy1=1", rsp0_valid, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      wait_rsp(1, lat, z, v);
      checks++;
      if (lat !== 1 || z !== e1[W-1:0] || v !== e1[W]) begin
         errors++; $display("FAIL bp_port1_result got lat=%0d Z=%h V=%b exp lat=1 Z=%h V=%b",
                             lat, z, v, e1[W-1:0], e1[W]);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      int w;
      int stale;
      clear_inputs();
      do_reset();
      do_req(0, $urandom, $urandom, 6'b011110, 1'b1, w);
      // now in the EXEC cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         errors++; $display("FAIL midop_rsp_valid got v0=%b v1=%b exp 0 0", rsp0_valid, rsp1_valid);
      end
      checks++;
      if ({alu_A, alu_B, alu_ALUFun, alu_Sign} !== '0) begin
         errors++; $display("FAIL midop_alu got A=%h B=%h F=%b S=%b exp all 0",
                             alu_A, alu_B, alu_ALUFun, alu_Sign);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL midop_idle got=%b exp=10", {req0_ready, req1_ready});
      end
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) stale++;
      end
      checks++;
      if (stale !== 0) begin
         errors++; $display("FAIL midop_stale got=%0d valid cycles exp=0", stale);
      end
      tick();
   endtask

   // Random traffic against a fairness model: after any grant the other
   // port is favoured next time both request.
   task automatic test_random();
      logic [W-1:0]  a0, b0, a1, b1, z;
      logic [FW-1:0] f0, f1;
      logic          s0, s1, v;
      logic [W:0]    e;
      int mode, gp, exp_gp, lat, hold, model_ptr, unstable;
      clear_inputs();
      do_reset();
      model_ptr = 0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      for (int n = 0; n < 30; n++) begin
         mode = $urandom_range(0, 2);
         a0 = $urandom; b0 = $urandom; f0 = pick_op(); s0 = 1'($urandom_range(0, 1));
         a1 = $urandom; b1 = $urandom; f1 = pick_op(); s1 = 1'($urandom_range(0, 1));
         req0_A = a0; req0_B = b0; req0_ALUFun = f0; req0_Sign = s0;
         req1_A = a1; req1_B = b1; req1_ALUFun = f1; req1_Sign = s1;
         req0_valid = (mode != 1);
         req1_valid = (mode != 0);
         exp_gp = (mode == 2) ? (FIXED_PRIO ? 0 : model_ptr) : mode;
         gp = -1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) gp = 0;
            else if (req1_valid && req1_ready) gp = 1;
            if (gp >= 0) break;
            tick();
         end
         checks++;
         if (gp !== exp_gp) begin
            errors++; $display("FAIL rnd%0d_grant got=%0d exp=%0d mode=%0d", n, gp, exp_gp, mode);
         end
         tick();
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         if (gp < 0) continue;
         model_ptr = 1 - gp;
         e = (gp == 0) ? alu_ref(a0, b0, f0, s0) : alu_ref(a1, b1, f1, s1);
         wait_rsp(gp, lat, z, v);
         checks++;
         if (lat !== 1 || z !== e[W-1:0] || v !== e[W]) begin
            errors++; $display("FAIL rnd%0d_result got lat=%0d Z=%h V=%b exp lat=1 Z=%h V=%b",
                                n, lat, z, v, e[W-1:0], e[W]);
         end
         checks++;
         if (((gp == 0) ? rsp1_valid : rsp0_valid) !== 1'b0) begin
            errors++; $display("FAIL rnd%0d_other_rsp got=1 exp=0", n);
         end
         hold = $urandom_range(0, 3);
         unstable = 0;
         for (int k = 0; k < hold; k++) begin
            tick();
            @(negedge clk);
            if (gp == 0 && (rsp0_valid !== 1'b1 || rsp0_Z !== z || rsp0_V !== v)) unstable++;
            if (gp == 1 && (rsp1_valid !== 1'b1 || rsp1_Z !== z || rsp1_V !== v)) unstable++;
         end
         checks++;
         if (unstable !== 0) begin
            errors++; $display("FAIL rnd%0d_stable got=%0d changed cycles exp=0", n, unstable);
         end
         tick();
         if (gp == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
         tick();
         rsp0_ready = 1'b0;
         rsp1_ready = 1'b0;
         @(negedge clk);
         checks++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            errors++; $display("FAIL rnd%0d_release got=%b exp=00", n, {rsp0_valid, rsp1_valid});
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_port0_add();
      test_port1_shift();
      test_overflow();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
